// File: rtl/logo_bouncer.sv
// Bouncing-logo position engine: owns the logo's top-left corner and direction,
// moves it by a per-axis step on each qualified tick and reports edge/corner hits.
module logo_bouncer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int CW    = 10,
    parameter int SW    = 4,
    parameter int X0    = 430,
    parameter int Y0    = 50,
    parameter int BCW   = 16
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            tick,
    input  logic            run,
    input  logic            load,
    input  logic [CW-1:0]   load_x,
    input  logic [CW-1:0]   load_y,
    input  logic [SW-1:0]   step_x,
    input  logic [SW-1:0]   step_y,
    input  logic [CW-1:0]   logo_length,
    input  logic [CW-1:0]   logo_hight,
    output logic [CW-1:0]   logo_x,
    output logic [CW-1:0]   logo_y,
    output logic            dir_x,
    output logic            dir_y,
    output logic            hit_x,
    output logic            hit_y,
    output logic            corner,
    output logic [BCW-1:0]  bounce_cnt,
    output logic            moving
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [CW-1:0] H_LIM = CW'(H_RES);
    localparam logic [CW-1:0] V_LIM = CW'(V_RES);
    localparam logic [CW-1:0] X_RST = CW'(X0);
    localparam logic [CW-1:0] Y_RST = CW'(Y0);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] x_max;
    logic [CW-1:0] y_max;
    logic          mv;
    logic [CW+1:0] res_x;
    logic [CW+1:0] res_y;

    // One axis move; result packs {hit, dir, pos}. Out-of-range clamping takes
    // priority so a shrinking window always pulls the logo back inside.
    function automatic logic [CW+1:0] axis_move(
        input logic [CW-1:0] pos,
        input logic          dir,
        input logic [SW-1:0] step,
        input logic [CW-1:0] lim
    );
        logic [CW:0] nxt;
        nxt = '0;
        if (pos > lim) begin
            axis_move = {1'b1, 1'b1, lim};
        end else if (lim == '0 || step == '0) begin
            axis_move = {1'b0, dir, pos};
        end else if (!dir) begin
            nxt = {1'b0, pos} + (CW+1)'(step);
            if (nxt >= {1'b0, lim})
                axis_move = {1'b1, 1'b1, lim};
            else
                axis_move = {1'b0, 1'b0, nxt[CW-1:0]};
        end else begin
            nxt = {1'b0, pos} - (CW+1)'(step);
            if (nxt[CW] || nxt == '0)
                axis_move = {1'b1, 1'b0, {CW{1'b0}}};
            else
                axis_move = {1'b0, 1'b1, nxt[CW-1:0]};
        end
    endfunction

    assign x_max  = (logo_length < H_LIM) ? (H_LIM - logo_length) : '0;
    assign y_max  = (logo_hight  < V_LIM) ? (V_LIM - logo_hight)  : '0;
    assign mv     = (state == RUN) && tick;
    assign moving = (state == RUN);
    assign res_x  = axis_move(logo_x, dir_x, step_x, x_max);
    assign res_y  = axis_move(logo_y, dir_y, step_y, y_max);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run)  state_nxt = RUN;
            RUN:     if (!run) state_nxt = HOLD;
            HOLD:    if (run)  state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            logo_x     <= X_RST;
            logo_y     <= Y_RST;
            dir_x      <= 1'b0;
            dir_y      <= 1'b1;
            hit_x      <= 1'b0;
            hit_y      <= 1'b0;
            corner     <= 1'b0;
            bounce_cnt <= '0;
        end else begin
            state  <= state_nxt;
            hit_x  <= 1'b0;
            hit_y  <= 1'b0;
            corner <= 1'b0;
            if (load) begin
                // load wins over a coincident move and never counts as a bounce
                logo_x <= (load_x > x_max) ? x_max : load_x;
                logo_y <= (load_y > y_max) ? y_max : load_y;
            end else if (mv) begin
                logo_x <= res_x[CW-1:0];
                dir_x  <= res_x[CW];
                hit_x  <= res_x[CW+1];
                logo_y <= res_y[CW-1:0];
                dir_y  <= res_y[CW];
                hit_y  <= res_y[CW+1];
                corner <= res_x[CW+1] & res_y[CW+1];
                if ((res_x[CW+1] | res_y[CW+1]) && bounce_cnt != '1)
                    bounce_cnt <= bounce_cnt + BCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_logo_bouncer.sv
// Directed bench for logo_bouncer: a table of per-cycle vectors plus hand-written
// pause/resume and asynchronous-reset sequences.
module tb_logo_bouncer;

    logic        pclk = 1'b0;
    logic        rst;
    logic        tick, run, load;
    logic [9:0]  load_x, load_y, logo_length, logo_hight;
    logic [3:0]  step_x, step_y;
    logic [9:0]  logo_x, logo_y;
    logic        dir_x, dir_y, hit_x, hit_y, corner, moving;
    logic [15:0] bounce_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logo_bouncer dut (
        .pclk(pclk), .rst(rst), .tick(tick), .run(run), .load(load),
        .load_x(load_x), .load_y(load_y), .step_x(step_x), .step_y(step_y),
        .logo_length(logo_length), .logo_hight(logo_hight),
        .logo_x(logo_x), .logo_y(logo_y), .dir_x(dir_x), .dir_y(dir_y),
        .hit_x(hit_x), .hit_y(hit_y), .corner(corner),
        .bounce_cnt(bounce_cnt), .moving(moving)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        rst_n, run, tick, load;
        logic [9:0]  lx, ly;
        logic [3:0]  sx, sy;
        logic [9:0]  len, hgt;
        logic [9:0]  ex, ey;
        logic        edx, edy, ehx, ehy, ec;
        logic [15:0] ecnt;
        logic        emov;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [9:0] ex, input logic [9:0] ey,
                         input logic edx, input logic edy, input logic ehx, input logic ehy,
                         input logic ec, input logic [15:0] ecnt, input logic emov);
        n_cmp++;
        if ({logo_x, logo_y, dir_x, dir_y, hit_x, hit_y, corner, bounce_cnt, moving} !==
            {ex, ey, edx, edy, ehx, ehy, ec, ecnt, emov}) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d dx=%b dy=%b hx=%b hy=%b c=%b cnt=%0d mov=%b, want x=%0d y=%0d dx=%b dy=%b hx=%b hy=%b c=%b cnt=%0d mov=%b",
                     name, logo_x, logo_y, dir_x, dir_y, hit_x, hit_y, corner, bounce_cnt, moving,
                     ex, ey, edx, edy, ehx, ehy, ec, ecnt, emov);
        end
    endtask

    task automatic cycle();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        //          rst run tk ld  lx   ly   sx sy len  hgt  ex   ey   dx dy hx hy c  cnt mov
        tbl[0]  = '{1, 1, 0, 0, 0,   0,   1, 1, 100, 40, 430, 50,  0, 1, 0, 0, 0, 0, 1};
        tbl[1]  = '{1, 1, 1, 0, 0,   0,   1, 1, 100, 40, 431, 49,  0, 1, 0, 0, 0, 0, 1};
        tbl[2]  = '{1, 1, 0, 1, 535, 1,   3, 3, 100, 40, 535, 1,   0, 1, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 1, 1, 0, 0,   0,   3, 3, 100, 40, 538, 0,   0, 0, 0, 1, 0, 1, 1};
        tbl[4]  = '{1, 1, 1, 0, 0,   0,   3, 3, 100, 40, 540, 3,   1, 0, 1, 0, 0, 2, 1};
        tbl[5]  = '{1, 1, 1, 0, 0,   0,   3, 3, 100, 40, 537, 6,   1, 0, 0, 0, 0, 2, 1};
        tbl[6]  = '{1, 1, 0, 0, 0,   0,   3, 3, 100, 40, 537, 6,   1, 0, 0, 0, 0, 2, 1};
        tbl[7]  = '{0, 0, 0, 0, 0,   0,   3, 3, 100, 40, 430, 50,  0, 1, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 0, 0,   0,   2, 2, 100, 40, 430, 50,  0, 1, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 1, 0, 1, 539, 1,   2, 2, 100, 40, 539, 1,   0, 1, 0, 0, 0, 0, 1};
        tbl[10] = '{1, 1, 1, 0, 0,   0,   2, 2, 100, 40, 540, 0,   1, 0, 1, 1, 1, 1, 1};
        tbl[11] = '{0, 0, 0, 0, 0,   0,   0, 0, 100, 40, 430, 50,  0, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{1, 1, 0, 0, 0,   0,   0, 0, 100, 40, 430, 50,  0, 1, 0, 0, 0, 0, 1};
        tbl[13] = '{1, 1, 0, 1, 500, 200, 0, 0, 100, 40, 500, 200, 0, 1, 0, 0, 0, 0, 1};
        tbl[14] = '{1, 1, 1, 0, 0,   0,   0, 0, 200, 40, 440, 200, 1, 1, 1, 0, 0, 1, 1};
        tbl[15] = '{1, 1, 1, 0, 0,   0,   0, 0, 700, 40, 0,   200, 1, 1, 1, 0, 0, 2, 1};
        tbl[16] = '{1, 1, 1, 0, 0,   0,   2, 0, 700, 40, 0,   200, 1, 1, 0, 0, 0, 2, 1};
        tbl[17] = '{1, 1, 1, 1, 700, 700, 1, 1, 100, 40, 540, 440, 1, 1, 0, 0, 0, 2, 1};

        rst = 1'b0; run = 1'b0; tick = 1'b0; load = 1'b0;
        load_x = '0; load_y = '0; step_x = 4'd1; step_y = 4'd1;
        logo_length = 10'd100; logo_hight = 10'd40;
        cycle();
        cycle();
        check("reset", 430, 50, 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst_n; run = tbl[i].run; tick = tbl[i].tick; load = tbl[i].load;
            load_x = tbl[i].lx; load_y = tbl[i].ly; step_x = tbl[i].sx; step_y = tbl[i].sy;
            logo_length = tbl[i].len; logo_hight = tbl[i].hgt;
            cycle();
            check($sformatf("vec%0d", i), tbl[i].ex, tbl[i].ey, tbl[i].edx, tbl[i].edy,
                  tbl[i].ehx, tbl[i].ehy, tbl[i].ec, tbl[i].ecnt, tbl[i].emov);
        end

        // run drops together with a tick: that move still happens, then HOLD
        load = 1'b0; run = 1'b0; tick = 1'b1; step_x = 4'd1; step_y = 4'd1;
        cycle();
        check("run_drop_tick", 539, 439, 1, 1, 0, 0, 0, 2, 0);
        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("hold%0d", i), 539, 439, 1, 1, 0, 0, 0, 2, 0);
        end
        run = 1'b1; tick = 1'b0;
        cycle();
        check("resume", 539, 439, 1, 1, 0, 0, 0, 2, 1);
        tick = 1'b1;
        cycle();
        check("resume_move", 538, 438, 1, 1, 0, 0, 0, 2, 1);

        // asynchronous reset takes effect without a clock edge
        #2 rst = 1'b0;
        #1;
        check("async_reset", 430, 50, 0, 1, 0, 0, 0, 0, 0);
        cycle();
        check("reset_held", 430, 50, 0, 1, 0, 0, 0, 0, 0);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
